rx_chan_src_mux: RTL

Parametrised RX channel-source stage sitting between the DDC chains and `rx_buffer`. It selects, per sample strobe, between live DDC data, TX loopback, and 16- or 32-bit test counters for `NCHAN` I/Q channel pairs. It also provides an armed multi-board sync capture that yields a one-cycle `sync_rx` pulse and clears all counters. It generalises the fixed 4-channel counter/loopback muxing into a registered, width- and channel-count-parametrised block with an explicit sync state machine.

---
 rtl/rx_chan_src_mux.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/rx_chan_src_mux.sv
// ---------------------------------------------------------------------------
// rx_chan_src_mux
//
// RX channel-source stage between the DDC chains and rx_buffer. On every
// accepted sample strobe it registers one word per I/Q channel pair, taken
// from live DDC data, TX loopback, or a test counter. An armed multi-board
// sync capture yields a one-cycle sync_rx pulse that also clears the counters.
//
// Optional feature macro: COUNTER_32BIT_EN
//   defined   -> 32-bit counter and mode 3 are built
//   undefined -> no 32-bit counter; mode 3 behaves exactly like mode 2
//
// Parameters
//   NCHAN     number of I/Q channel pairs (1..8)
//   WIDTH     sample width (>=16); counter words fill the low 16 bits
//   SYNC_EDGE 1 = rising edge of sync_in triggers, 0 = falling edge
//
// Ports
//   clock       in   sample clock
//   reset       in   asynchronous, active-high
//   enable      in   RX enable
//   strobe      in   RX output sample strobe
//   tx_strobe   in   TX interpolator strobe, qualifies loopback capture
//   tx_i, tx_q  in   TX baseband for loopback
//   bb_i, bb_q  in   packed DDC outputs, channel k at [k*WIDTH +: WIDTH]
//   mode        in   0 normal, 1 loopback, 2 counter16, 3 counter32
//   sync_arm    in   one-cycle arm request
//   sync_in     in   asynchronous external sync pin
//   ch_out      out  packed {q,i} per channel at [2k*WIDTH +: 2*WIDTH]
//   ch_valid    out  one-cycle qualifier for ch_out
//   sync_rx     out  one-cycle sync pulse
//   sync_state  out  0 IDLE, 1 ARMED, 2 SYNCED
// ---------------------------------------------------------------------------
module rx_chan_src_mux #(
  parameter int NCHAN     = 4,
  parameter int WIDTH     = 16,
  parameter int SYNC_EDGE = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     strobe,
  input  logic                     tx_strobe,
  input  logic [WIDTH-1:0]         tx_i,
  input  logic [WIDTH-1:0]         tx_q,
  input  logic [NCHAN*WIDTH-1:0]   bb_i,
  input  logic [NCHAN*WIDTH-1:0]   bb_q,
  input  logic [1:0]               mode,
  input  logic                     sync_arm,
  input  logic                     sync_in,
  output logic [2*NCHAN*WIDTH-1:0] ch_out,
  output logic                     ch_valid,
  output logic                     sync_rx,
  output logic [1:0]               sync_state
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ARMED  = 2'd1;
  localparam logic [1:0] ST_SYNCED = 2'd2;

  // Slot used for channel 1 in mode 3; kept in range when NCHAN == 1.
  localparam int CH1 = (NCHAN >= 2) ? 1 : 0;

  // Zero-extend a 16-bit counter word to the sample width.
  function automatic logic [WIDTH-1:0] ext16(input logic [15:0] v);
    ext16 = WIDTH'(v);
  endfunction

  logic [WIDTH-1:0]         lb_i_q, lb_q_q;
  logic                     sync_meta_q, sync_s2_q, sync_prev_q, edge_q;
  logic                     edge_raw;
  logic [1:0]               state_q, state_d;
  logic                     sync_rx_q, sync_rx_d;
  logic                     accept;
  logic [15:0]              cnt16_q, cnt16_d, cnt16_p1;
  logic [2*NCHAN*WIDTH-1:0] ch_out_q, sample_d;
  logic                     ch_valid_q;
`ifdef COUNTER_32BIT_EN
  logic [31:0]              cnt32_q, cnt32_d;
`endif

  // A sample is dropped on the sync pulse cycle so the first post-sync word
  // starts cleanly from counter value zero.
  assign accept = strobe & enable & ~sync_rx_q;

  // -------------------------------------------------------------------------
  // Loopback capture: follows tx_strobe regardless of enable/mode.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lb_i_q <= '0;
      lb_q_q <= '0;
    end else if (tx_strobe) begin
      lb_i_q <= tx_i;
      lb_q_q <= tx_q;
    end
  end

  // -------------------------------------------------------------------------
  // sync_in: two-flop synchroniser, edge detector on the second flop, and a
  // registered edge pulse feeding the FSM.
  // -------------------------------------------------------------------------
  assign edge_raw = (SYNC_EDGE != 0) ? (sync_s2_q & ~sync_prev_q)
                                     : (~sync_s2_q & sync_prev_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta_q <= 1'b0;
      sync_s2_q   <= 1'b0;
      sync_prev_q <= 1'b0;
      edge_q      <= 1'b0;
    end else begin
      sync_meta_q <= sync_in;
      sync_s2_q   <= sync_meta_q;
      sync_prev_q <= sync_s2_q;
      edge_q      <= edge_raw;
    end
  end

  // -------------------------------------------------------------------------
  // Sync FSM. Only an ARMED block reacts to an edge; an arm request that
  // coincides with an edge while IDLE just arms.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    sync_rx_d = 1'b0;
    case (state_q)
      ST_IDLE:   if (sync_arm) state_d = ST_ARMED;
      ST_ARMED:  if (edge_q) begin
                   state_d   = ST_SYNCED;
                   sync_rx_d = 1'b1;
                 end
      ST_SYNCED: if (sync_arm) state_d = ST_ARMED;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sync_rx_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_rx_q <= sync_rx_d;
    end
  end

  // -------------------------------------------------------------------------
  // Test counters: advance per accepted strobe, cleared while disabled or on
  // the sync pulse.
  // -------------------------------------------------------------------------
  always_comb begin
    cnt16_d = cnt16_q;
    if (!enable || sync_rx_q) cnt16_d = 16'd0;
    else if (accept)          cnt16_d = cnt16_q + 16'd2;
  end

  assign cnt16_p1 = cnt16_q + 16'd1;

`ifdef COUNTER_32BIT_EN
  always_comb begin
    cnt32_d = cnt32_q;
    if (!enable || sync_rx_q) cnt32_d = 32'd0;
    else if (accept)          cnt32_d = cnt32_q + 32'd1;
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt16_q <= 16'd0;
`ifdef COUNTER_32BIT_EN
      cnt32_q <= 32'd0;
`endif
    end else begin
      cnt16_q <= cnt16_d;
`ifdef COUNTER_32BIT_EN
      cnt32_q <= cnt32_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Source mux: every channel defaults to DDC pass-through; the selected mode
  // overrides channel 0 (and channel 1 in mode 3).
  // -------------------------------------------------------------------------
  always_comb begin
    sample_d = '0;
    for (int k = 0; k < NCHAN; k++) begin
      sample_d[(2*k)*WIDTH   +: WIDTH] = bb_i[k*WIDTH +: WIDTH];
      sample_d[(2*k+1)*WIDTH +: WIDTH] = bb_q[k*WIDTH +: WIDTH];
    end
    case (mode)
      2'd1: begin
        sample_d[0     +: WIDTH] = lb_i_q;
        sample_d[WIDTH +: WIDTH] = lb_q_q;
      end
      2'd2: begin
        sample_d[0     +: WIDTH] = ext16(cnt16_q);
        sample_d[WIDTH +: WIDTH] = ext16(cnt16_p1);
      end
      2'd3: begin
`ifdef COUNTER_32BIT_EN
        sample_d[0     +: WIDTH] = ext16(cnt32_q[31:16]);
        sample_d[WIDTH +: WIDTH] = ext16(cnt32_q[15:0]);
        // Channel 0 of the DDC is displaced onto channel 1.
        if (NCHAN >= 2) begin
          sample_d[(2*CH1)*WIDTH   +: WIDTH] = bb_i[0 +: WIDTH];
          sample_d[(2*CH1+1)*WIDTH +: WIDTH] = bb_q[0 +: WIDTH];
        end
`else
        sample_d[0     +: WIDTH] = ext16(cnt16_q);
        sample_d[WIDTH +: WIDTH] = ext16(cnt16_p1);
`endif
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output register: loads on accept, otherwise holds.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ch_out_q   <= '0;
      ch_valid_q <= 1'b0;
    end else begin
      ch_valid_q <= accept;
      if (accept) ch_out_q <= sample_d;
    end
  end

  assign ch_out     = ch_out_q;
  assign ch_valid   = ch_valid_q;
  assign sync_rx    = sync_rx_q;
  assign sync_state = state_q;

endmodule
